// File: rtl/mul_issue.sv
`default_nettype none
// ============================================================================
// mul_issue : request sequencer for the two-cycle execute_mul multiplier,
//             with operand hold during the result cycle and a result register.
// Rev 1.0
// ============================================================================
module mul_issue #(
  parameter int TAG_W = 5,
  parameter int REGSZ = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [5:0]       req_op,
  input  logic [REGSZ-1:0] req_a,
  input  logic [REGSZ-1:0] req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             mul_enable,
  output logic [5:0]       mul_op,
  output logic [REGSZ-1:0] mul_a,
  output logic [REGSZ-1:0] mul_b,
  input  logic [REGSZ-1:0] mul_out,
  input  logic             mul_ov,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [REGSZ-1:0] res_value,
  output logic             res_ov,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    SUM   = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [5:0]         op_q, op_d;
  logic [REGSZ-1:0]   a_q, a_d;
  logic [REGSZ-1:0]   b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic               res_valid_q, res_valid_d;
  logic [REGSZ-1:0]   res_value_q, res_value_d;
  logic               res_ov_q, res_ov_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic               capture;
  logic               accept;

  always_comb begin
    capture     = (state_q == SUM) && (!res_valid_q || res_ready);
    req_ready   = !flush && ((state_q == IDLE) || capture);
    accept      = req_valid && req_ready;

    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    tag_d       = tag_q;
    res_valid_d = res_valid_q;
    res_value_d = res_value_q;
    res_ov_d    = res_ov_q;
    res_tag_d   = res_tag_q;

    if (flush) begin
      // Kill everything in flight and held; operands are left as they were.
      state_d     = IDLE;
      res_valid_d = 1'b0;
    end else begin
      if (accept) begin
        op_d  = req_op;
        a_d   = req_a;
        b_d   = req_b;
        tag_d = req_tag;
      end

      case (state_q)
        IDLE:    if (accept) state_d = ISSUE;
        ISSUE:   state_d = SUM;
        SUM:     if (capture) state_d = accept ? ISSUE : IDLE;
        default: state_d = IDLE;
      endcase

      // A capture overrides a simultaneous drain: the slot refills in place.
      if (capture) begin
        res_valid_d = 1'b1;
        res_value_d = mul_out;
        res_ov_d    = mul_ov;
        res_tag_d   = tag_q;
      end else if (res_valid_q && res_ready) begin
        res_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      tag_q       <= '0;
      res_valid_q <= 1'b0;
      res_value_q <= '0;
      res_ov_q    <= 1'b0;
      res_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      tag_q       <= tag_d;
      res_valid_q <= res_valid_d;
      res_value_q <= res_value_d;
      res_ov_q    <= res_ov_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign mul_enable = (state_q == ISSUE);
  assign mul_op     = op_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign res_valid  = res_valid_q;
  assign res_value  = res_value_q;
  assign res_ov     = res_ov_q;
  assign res_tag    = res_tag_q;
  assign busy       = (state_q != IDLE) || res_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_issue.sv
`default_nettype none
// tb_mul_issue : directed and randomized checks of mul_issue against a
// reference multiply model and an in-order expected-result queue.
module tb_mul_issue;

  localparam logic [5:0] EXOP_MUL_AB     = 6'd20;
  localparam logic [5:0] EXOP_MUL_HW_AB  = 6'd21;
  localparam logic [5:0] EXOP_MUL_HWU_AB = 6'd22;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [4:0]  req_tag = '0;
  logic        flush = 1'b0;
  logic        mul_enable;
  logic [5:0]  mul_op;
  logic [31:0] mul_a, mul_b, mul_out;
  logic        mul_ov;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [31:0] res_value;
  logic        res_ov;
  logic [4:0]  res_tag;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] v;
    logic        ov;
    logic [4:0]  tag;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  mul_issue #(.TAG_W(5), .REGSZ(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .mul_enable(mul_enable), .mul_op(mul_op), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out(mul_out), .mul_ov(mul_ov),
    .res_valid(res_valid), .res_ready(res_ready), .res_value(res_value),
    .res_ov(res_ov), .res_tag(res_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Plain-arithmetic meaning of each multiply op: {ov, value}.
  function automatic logic [32:0] mulf(input logic [5:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    logic signed [63:0] ps;
    logic [63:0]        pu;
    ps = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    pu = {32'd0, a} * {32'd0, b};
    case (op)
      EXOP_MUL_AB:     mulf = {(ps[63:32] != {32{ps[31]}}), ps[31:0]};
      EXOP_MUL_HW_AB:  mulf = {1'b0, ps[63:32]};
      EXOP_MUL_HWU_AB: mulf = {1'b0, pu[63:32]};
      default:         mulf = 33'd0;
    endcase
  endfunction

  // Multiplier stand-in: captures its inputs on the enable edge.
  logic [5:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0;
  always @(posedge clk) if (mul_enable) begin
    m_op <= mul_op;
    m_a  <= mul_a;
    m_b  <= mul_b;
  end
  assign {mul_ov, mul_out} = mulf(m_op, m_a, m_b);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on each delivered result.
  always @(negedge clk) begin
    if (!reset || flush) begin
      exp_q.delete();
    end else begin
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_phantom: got result tag %0d value 0x%0h, expected none", res_tag, res_value);
        end else begin
          mon_e = exp_q.pop_front();
          check("sb_value", {32'd0, res_value}, {32'd0, mon_e.v});
          check("sb_ov", {63'd0, res_ov}, {63'd0, mon_e.ov});
          check("sb_tag", {59'd0, res_tag}, {59'd0, mon_e.tag});
        end
      end
      if (req_valid && req_ready) begin
        mon_e.v   = mulf(req_op, req_a, req_b) & 33'h0_FFFF_FFFF;
        mon_e.ov  = mulf(req_op, req_a, req_b) >> 32;
        mon_e.tag = req_tag;
        exp_q.push_back(mon_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    bit got = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!got) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_one(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] tag,
                         input logic [31:0] ev, input logic eov);
    send(op, a, b, tag);
    tick();
    check({name, "_early"}, {63'd0, res_valid}, 64'd0);
    tick();
    check({name, "_valid"}, {63'd0, res_valid}, 64'd1);
    check({name, "_value"}, {32'd0, res_value}, {32'd0, ev});
    check({name, "_ov"}, {63'd0, res_ov}, {63'd0, eov});
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held_v;
    bit          acc;
    int          sel;

    #2 reset = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_res_valid", {63'd0, res_valid}, 64'd0);
    check("rst_res_value", {32'd0, res_value}, 64'd0);
    check("rst_res_ov", {63'd0, res_ov}, 64'd0);
    check("rst_res_tag", {59'd0, res_tag}, 64'd0);
    check("rst_mul_enable", {63'd0, mul_enable}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b1;
    tick();

    // Basic latency and single-cycle enable.
    res_ready = 1'b1;
    send(EXOP_MUL_AB, 32'd3, 32'd5, 5'd7);
    check("t1_enable_issue", {63'd0, mul_enable}, 64'd1);
    check("t1_valid_e0", {63'd0, res_valid}, 64'd0);
    tick();
    check("t1_enable_sum", {63'd0, mul_enable}, 64'd0);
    check("t1_valid_e1", {63'd0, res_valid}, 64'd0);
    tick();
    check("t1_valid_e2", {63'd0, res_valid}, 64'd1);
    check("t1_value", {32'd0, res_value}, 64'd15);
    check("t1_ov", {63'd0, res_ov}, 64'd0);
    check("t1_tag", {59'd0, res_tag}, 64'd7);
    tick();
    check("t1_drained", {63'd0, res_valid}, 64'd0);

    run_one("ovf", EXOP_MUL_AB, 32'h0001_0000, 32'h0001_0000, 5'd8, 32'h0, 1'b1);
    run_one("zero", EXOP_MUL_AB, 32'h0, 32'h123, 5'd9, 32'h0, 1'b0);
    run_one("hwu", EXOP_MUL_HWU_AB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10, 32'hFFFF_FFFE, 1'b0);
    run_one("hw", EXOP_MUL_HW_AB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'h0, 1'b0);

    // Back-pressure: tag 1 held while tag 2 stalls in SUM.
    res_ready = 1'b0;
    send(EXOP_MUL_AB, 32'h1234, 32'h10, 5'd1);
    send(EXOP_MUL_HWU_AB, 32'h8000_0000, 32'd4, 5'd2);
    held_v = res_value;
    check("bp_first_value", {32'd0, held_v}, 64'h12340);
    for (int i = 0; i < 6; i++) begin
      check("bp_hold_valid", {63'd0, res_valid}, 64'd1);
      check("bp_hold_tag", {59'd0, res_tag}, 64'd1);
      check("bp_hold_value", {32'd0, res_value}, 64'h12340);
      check("bp_mul_a", {32'd0, mul_a}, 64'h8000_0000);
      check("bp_mul_b", {32'd0, mul_b}, 64'd4);
      check("bp_mul_op", {58'd0, mul_op}, {58'd0, EXOP_MUL_HWU_AB});
      check("bp_req_ready", {63'd0, req_ready}, 64'd0);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("bp_second_valid", {63'd0, res_valid}, 64'd1);
    check("bp_second_tag", {59'd0, res_tag}, 64'd2);
    check("bp_second_value", {32'd0, res_value}, 64'd2);
    tick();
    check("bp_drained", {63'd0, res_valid}, 64'd0);

    // Flush while a result is held and another op waits in SUM.
    res_ready = 1'b0;
    send(EXOP_MUL_AB, 32'd7, 32'd6, 5'd3);
    send(EXOP_MUL_AB, 32'd9, 32'd9, 5'd4);
    tick();
    check("fl_pre_valid", {63'd0, res_valid}, 64'd1);
    flush = 1'b1;
    tick();
    check("fl_res_valid", {63'd0, res_valid}, 64'd0);
    check("fl_ready_during", {63'd0, req_ready}, 64'd0);
    flush = 1'b0;
    #1;
    check("fl_req_ready", {63'd0, req_ready}, 64'd1);
    check("fl_busy", {63'd0, busy}, 64'd0);
    res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("fl_no_result", {63'd0, res_valid}, 64'd0);
    end

    // Asynchronous reset in the middle of ISSUE.
    send(EXOP_MUL_AB, 32'd5, 32'd5, 5'd9);
    #2 reset = 1'b0;
    #1;
    check("ar_mul_enable", {63'd0, mul_enable}, 64'd0);
    check("ar_res_valid", {63'd0, res_valid}, 64'd0);
    check("ar_mul_a", {32'd0, mul_a}, 64'd0);
    check("ar_busy", {63'd0, busy}, 64'd0);
    check("ar_req_ready", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    run_one("ar_neg", EXOP_MUL_AB, 32'd2, 32'hFFFF_FFFC, 5'd11, 32'hFFFF_FFF8, 1'b0);

    // Randomized traffic with back-pressure and occasional flush.
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      acc = req_valid && req_ready;
      @(posedge clk);
      #1;
      if (acc || !req_valid) begin
        req_valid = ($urandom_range(0, 3) != 0);
        sel = $urandom_range(0, 2);
        req_op = (sel == 0) ? EXOP_MUL_AB : (sel == 1) ? EXOP_MUL_HW_AB : EXOP_MUL_HWU_AB;
        case ($urandom_range(0, 2))
          0: begin req_a = $urandom; req_b = $urandom; end
          1: begin req_a = $urandom_range(0, 32'hFFFF); req_b = $urandom_range(0, 32'hFFFF); end
          default: begin req_a = -$urandom_range(0, 300); req_b = $urandom_range(0, 32'h1FFFF); end
        endcase
        req_tag = 5'($urandom);
      end
      res_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 29) == 0);
    end
    req_valid = 1'b0;
    flush     = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (exp_q.size() == 0) break;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    tick();
    check("drain_idle", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mul_issue.md
# mul_issue

Sequencer that sits directly upstream of the two-cycle `execute_mul` multiplier in the EXE stage. It accepts multiply requests over a valid/ready handshake, registers operands, and drives the multiplier's `enable`/`mul_op`/`in_a`/`in_b`. It holds those inputs stable for the combinational result cycle, then captures `out`/`ov` into a result register presented downstream over a second valid/ready handshake. Back-pressure and flush are handled without losing or reordering results.

## Interface
- `TAG_W`, default 5: width of the opaque destination tag carried alongside each operation.
- `clk` in 1: clock; all state on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: block accepts the request this cycle.
- `req_op` in 6: `EXOP_MUL_AB`, `EXOP_MUL_HW_AB` or `EXOP_MUL_HWU_AB` (`decode_enums.vh`).
- `req_a`, `req_b` in `REGSZ`: operands.
- `req_tag` in `TAG_W`: tag returned with the result.
- `flush` in 1: synchronous kill of all in-flight and unconsumed work.
- `mul_enable` out 1: to multiplier `enable`.
- `mul_op` out 6: to multiplier `mul_op`.
- `mul_a`, `mul_b` out `REGSZ`: to multiplier `in_a`/`in_b`.
- `mul_out` in `REGSZ`: from multiplier `out`.
- `mul_ov` in 1: from multiplier `ov`.
- `res_valid` out 1: result register holds a result.
- `res_ready` in 1: consumer takes the result this cycle.
- `res_value` out `REGSZ`: result.
- `res_ov` out 1: overflow flag (meaningful for `EXOP_MUL_AB` only).
- `res_tag` out `TAG_W`: tag of the result.
- `busy` out 1: state != IDLE or `res_valid`.

## Operation
- FSM states: IDLE, ISSUE, SUM. The result register (`res_valid`, `res_value`, `res_ov`, `res_tag`) is separate from the FSM.
- `capture = (state==SUM) && (!res_valid || res_ready)`.
- `req_ready = !flush && (state==IDLE || capture)`.
- `accept = req_valid && req_ready`. On accept, the operand registers (op, a, b, tag) load; next state is ISSUE.
- ISSUE: `mul_enable = 1` (decoded from the state flops). Next state is SUM unconditionally.
- SUM:
  - `mul_enable = 0`; operand registers held, so the multiplier's combinational `out`/`ov` (which depend on `mul_op`, `mul_a`, `mul_b`) stay valid.
  - If `capture`: load the result register from `mul_out`/`mul_ov`/tag and set `res_valid`. Next state is ISSUE if `accept` the same cycle, else IDLE.
  - Otherwise stay in SUM (stall).
- Downstream: `res_valid && res_ready` with no simultaneous capture clears `res_valid`. Simultaneous drain and capture leaves `res_valid` = 1 with the new contents.
- `mul_op`/`mul_a`/`mul_b` always reflect the operand registers. Ops outside the three legal values are passed through unchecked; the requester must not issue them.
- `flush` has priority over everything:
  - next state IDLE;
  - `res_valid` cleared;
  - no accept, no capture;
  - operand registers unchanged.
- Reset: state IDLE, every output register and operand register 0, so `req_ready` = 1, `res_valid` = 0, `res_value` = 0, `res_ov` = 0, `res_tag` = 0, `mul_enable` = 0, `busy` = 0.

## Timing
- Accept at edge E0 → ISSUE during E0..E1 (multiplier registers partial products at E1) → SUM during E1..E2 → `res_valid` = 1 after E2. Latency is 2 cycles from the accept edge.
- Throughput is one op per 2 cycles: accept is legal in the capture cycle, giving back-to-back results 2 cycles apart.
- Stall in SUM keeps `mul_*` constant. The result is captured on the first edge where the slot is free or draining.
- Results are delivered strictly in acceptance order; there is at most one in flight plus one held.
- Reset deassertion mid-operation: the block resumes from IDLE with no phantom result.

## Test plan
- Reset, then `EXOP_MUL_AB` 3×5 tag 7 with `res_ready`=1 → `res_valid` rises 2 edges after accept, `res_value` = 15, `res_ov` = 0, `res_tag` = 7, `mul_enable` high exactly one cycle.
- `EXOP_MUL_AB` 0x00010000×0x00010000 → `res_value` = 0, `res_ov` = 1. Then `EXOP_MUL_AB` 0×123 → 0, `res_ov` = 0.
- 0xFFFFFFFF×0xFFFFFFFF as `EXOP_MUL_HWU_AB` → 0xFFFFFFFE; as `EXOP_MUL_HW_AB` → 0x00000000. Both with `res_ov` = 0.
- Back-pressure: two requests (tags 1, 2) with `res_ready` = 0 for 6 cycles:
  - tag 1 result held stable;
  - second op stalls in SUM with `mul_a`/`mul_b`/`mul_op` constant and `req_ready` = 0;
  - raise `res_ready` → tag 1 drains, tag 2 appears the same edge, values correct.
- `flush` asserted during SUM with `res_valid` = 1 → next cycle `res_valid` = 0, state IDLE, `req_ready` = 1. No result for the killed op ever appears.
- Assert `reset` low asynchronously mid-ISSUE → all outputs 0 immediately. After release, a new `EXOP_MUL_AB` 2×(−4) → 0xFFFFFFF8, `res_ov` = 0.
